// File: rtl/output_writeback_pkg.sv
// Shared types and helpers for the output write-back path.
// wb_saturate is used only when WB_QUANTIZE_EN is defined.
package cpaed_wb_pkg;

   localparam int unsigned WB_ADDR_W = 20;
   localparam int unsigned WB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } wb_state_e;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

   // Linear output address; callers truncate to the memory address width so it wraps.
   function automatic logic [31:0] wb_addr(input int unsigned x,
                                           input int unsigned y,
                                           input int unsigned ch,
                                           input int unsigned fm_width,
                                           input int unsigned nb_ch,
                                           input int unsigned base);
      return base + (y * fm_width + x) * nb_ch + ch;
   endfunction

   // Clamp a signed value to the signed dw-bit range, returned sign-extended.
   function automatic logic [WB_DATA_W-1:0] wb_saturate(input logic signed [WB_DATA_W-1:0] v,
                                                       input int unsigned dw);
      longint max_v;
      longint min_v;
      longint vv;
      max_v = (longint'(1) <<< (dw - 1)) - longint'(1);
      min_v = -max_v - longint'(1);
      vv    = longint'(v);
      if (vv > max_v) begin
         vv = max_v;
      end else if (vv < min_v) begin
         vv = min_v;
      end
      return WB_DATA_W'(vv);
   endfunction

endpackage

// File: rtl/output_writeback_fifo.sv
// Synchronous write-buffer FIFO with registered full/empty flags.
// A push while full is accepted only when a pop frees a slot on the same edge.
module wb_fifo #(
   parameter int unsigned WIDTH = 52,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             arst_n_in,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_d;
   logic             push_ok;
   logic             pop_ok;

   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      count_d = count;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count + CW'(1);
         2'b01:   count_d = count - CW'(1);
         default: count_d = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!arst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count_d;
         full  <= (count_d == CW'(DEPTH));
         empty <= (count_d == '0);
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/output_writeback.sv
// Writes the accelerator output stream to external memory through a small FIFO,
// tracking layer completion and sticky errors. Optional macro: WB_QUANTIZE_EN.
module output_writeback
   import cpaed_wb_pkg::*;
#(
`ifdef WB_QUANTIZE_EN
   parameter int unsigned QUANT_SHIFT        = 8,
`endif
   parameter int unsigned ACCUMULATION_WIDTH = 32,
   parameter int unsigned DATA_WIDTH         = 16,
   parameter int unsigned EXT_MEM_HEIGHT     = 1 << 20,
   parameter int unsigned FEATURE_MAP_WIDTH  = 64,
   parameter int unsigned FEATURE_MAP_HEIGHT = 64,
   parameter int unsigned OUTPUT_NB_CHANNELS = 32,
   parameter int unsigned OUT_BASE           = 32'h8_0000,
   parameter int unsigned FIFO_DEPTH         = 8
) (
   input  logic                                    clk,
   input  logic                                    arst_n_in,
   input  logic                                    start,
   input  logic [ACCUMULATION_WIDTH-1:0]           out,
   input  logic                                    output_valid,
   input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    output_x,
   input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   output_y,
   input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch,
   output logic                                    mem_we,
   input  logic                                    mem_ready,
   output logic [$clog2(EXT_MEM_HEIGHT)-1:0]       mem_addr,
   output logic [ACCUMULATION_WIDTH-1:0]           mem_wdata,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    overflow_err,
   output logic                                    range_err,
   output logic                                    stray_err
);

   localparam int unsigned AW    = $clog2(EXT_MEM_HEIGHT);
   localparam int unsigned TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
   localparam int unsigned CNTW  = $clog2(TOTAL + 1);
   localparam int unsigned EW    = $bits(wb_entry_t);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("output_writeback: FIFO_DEPTH must be a power of two and at least 2");
   end
   if (DATA_WIDTH > ACCUMULATION_WIDTH) begin : g_bad_dw
      $error("output_writeback: DATA_WIDTH must not exceed ACCUMULATION_WIDTH");
   end

   wb_state_e            state_q;
   wb_state_e            state_d;
   logic                 busy_d;
   logic                 done_d;
   logic [CNTW-1:0]      cnt_q;
   logic                 s1_valid_q;
   wb_entry_t            s1_q;
   logic [WB_DATA_W-1:0] s1_data_c;
   wb_entry_t            head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;
   logic                 drop_full;
   logic                 sample;
   logic                 in_range;
   logic                 enter_run;

   assign enter_run = (state_q == IDLE) && start;
   assign sample    = output_valid && (state_q == RUN);
   assign in_range  = (32'(output_x)  < FEATURE_MAP_WIDTH)  &&
                      (32'(output_y)  < FEATURE_MAP_HEIGHT) &&
                      (32'(output_ch) < OUTPUT_NB_CHANNELS);

   assign pop       = !fifo_empty && mem_ready;
   assign drop_full = s1_valid_q && fifo_full && !pop;

`ifdef WB_QUANTIZE_EN
   logic signed [ACCUMULATION_WIDTH-1:0] shifted_c;
   assign shifted_c = $signed(out) >>> QUANT_SHIFT;
   assign s1_data_c = wb_saturate(WB_DATA_W'(shifted_c), DATA_WIDTH);
`else
   assign s1_data_c = WB_DATA_W'(out);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!arst_n_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d = state_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (sample && (cnt_q == CNTW'(TOTAL - 1))) state_d = DRAIN;
         DRAIN:   if (!s1_valid_q && fifo_empty) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   // Address stage, layer counter, status flags
   always_ff @(posedge clk) begin
      if (!arst_n_in) begin
         busy         <= 1'b0;
         done         <= 1'b0;
         cnt_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_q         <= '0;
         overflow_err <= 1'b0;
         range_err    <= 1'b0;
         stray_err    <= 1'b0;
      end else begin
         busy       <= busy_d;
         done       <= done_d;
         s1_valid_q <= sample && in_range;
         if (sample && in_range) begin
            s1_q.addr <= WB_ADDR_W'(wb_addr(32'(output_x), 32'(output_y), 32'(output_ch),
                                            FEATURE_MAP_WIDTH, OUTPUT_NB_CHANNELS, OUT_BASE));
            s1_q.data <= s1_data_c;
         end

         // Dropped entries still count so completion never stalls.
         if (enter_run) begin
            cnt_q <= '0;
         end else if (sample) begin
            cnt_q <= cnt_q + CNTW'(1);
         end

         if (enter_run) begin
            overflow_err <= 1'b0;
            range_err    <= 1'b0;
            stray_err    <= 1'b0;
         end
         if (drop_full) begin
            overflow_err <= 1'b1;
         end
         if (sample && !in_range) begin
            range_err <= 1'b1;
         end
         if (output_valid && (state_q != RUN)) begin
            stray_err <= 1'b1;
         end
      end
   end

   wb_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .push      (s1_valid_q),
      .pop       (pop),
      .din       (s1_q),
      .dout      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign mem_we    = !fifo_empty;
   assign mem_addr  = AW'(head.addr);
   assign mem_wdata = ACCUMULATION_WIDTH'(head.data);

endmodule

// File: tb/tb_output_writeback.sv
// Self-checking bench for output_writeback (reduced height of 3 keeps the full layer short
// and makes out-of-range y reachable).
`timescale 1ns/1ps
module tb_output_writeback;

   localparam int unsigned FMW   = 64;
   localparam int unsigned FMH   = 3;
   localparam int unsigned OCH   = 32;
   localparam int unsigned TOTAL = FMW * FMH * OCH;
   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        arst_n_in;
   logic        start;
   logic [31:0] out;
   logic        output_valid;
   logic [5:0]  output_x;
   logic [1:0]  output_y;
   logic [4:0]  output_ch;
   logic        mem_we;
   logic        mem_ready;
   logic [19:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        overflow_err;
   logic        range_err;
   logic        stray_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [51:0] exp_q[$];
   logic [51:0] obs_q[$];
   int          done_cnt = 0;
   logic        done_busy = 1'b0;

   output_writeback #(
      .FEATURE_MAP_WIDTH  (FMW),
      .FEATURE_MAP_HEIGHT (FMH),
      .OUTPUT_NB_CHANNELS (OCH),
      .FIFO_DEPTH         (DEPTH)
   ) dut (
      .clk          (clk),
      .arst_n_in    (arst_n_in),
      .start        (start),
      .out          (out),
      .output_valid (output_valid),
      .output_x     (output_x),
      .output_y     (output_y),
      .output_ch    (output_ch),
      .mem_we       (mem_we),
      .mem_ready    (mem_ready),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .busy         (busy),
      .done         (done),
      .overflow_err (overflow_err),
      .range_err    (range_err),
      .stray_err    (stray_err)
   );

   always #5 clk = ~clk;

   // Record every completed write and every done pulse
   always @(negedge clk) begin
      if (arst_n_in && mem_we && mem_ready) obs_q.push_back({mem_addr, mem_wdata});
      if (done) begin
         done_cnt++;
         done_busy = busy;
      end
   end

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1);
   end

   function automatic logic [19:0] ref_addr(input int unsigned x, input int unsigned y,
                                            input int unsigned ch);
      int unsigned a;
      a = 32'h8_0000 + (y * FMW + x) * OCH + ch;
      return a[19:0];
   endfunction

   function automatic logic [31:0] ref_data(input logic [31:0] d);
`ifdef WB_QUANTIZE_EN
      longint v;
      v = longint'($signed(d)) >>> 8;
      if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
      return v[31:0];
`else
      return d;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_out(input int unsigned x, input int unsigned y, input int unsigned ch,
                            input logic [31:0] d);
      output_valid = 1'b1;
      output_x     = 6'(x);
      output_y     = 2'(y);
      output_ch    = 5'(ch);
      out          = d;
   endtask

   task automatic do_reset();
      arst_n_in    = 1'b0;
      start        = 1'b0;
      output_valid = 1'b0;
      tick();
      arst_n_in = 1'b1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic send_rand(input bit expect_write);
      int unsigned x, y, ch;
      logic [31:0] d;
      x  = $urandom_range(0, FMW - 1);
      y  = $urandom_range(0, FMH - 1);
      ch = $urandom_range(0, OCH - 1);
      d  = $urandom;
      drive_out(x, y, ch, d);
      if (expect_write) exp_q.push_back({ref_addr(x, y, ch), ref_data(d)});
   endtask

   task automatic test_reset();
      arst_n_in = 1'b0; start = 1'b0; output_valid = 1'b0; mem_ready = 1'b0;
      out = '0; output_x = '0; output_y = '0; output_ch = '0;
      tick(); tick();
      arst_n_in = 1'b1;
      n_tests++;
      if ({mem_we, mem_addr, mem_wdata} !== 53'd0) begin
         n_fail++;
         $display("FAIL reset_port: got we=%b addr=%h data=%h, want all 0", mem_we, mem_addr, mem_wdata);
      end
      n_tests++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_status: got busy=%b done=%b, want 0 0", busy, done);
      end
      n_tests++;
      if ({overflow_err, range_err, stray_err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_errs: got %b%b%b, want 000", overflow_err, range_err, stray_err);
      end
   endtask

   task automatic test_stray();
      send_rand(1'b0);
      tick();
      output_valid = 1'b0;
      n_tests++;
      if (stray_err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_idle: got stray=%b busy=%b, want 1 0", stray_err, busy);
      end
      tick(); tick();
      n_tests++;
      if (stray_err !== 1'b1 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_sticky: got stray=%b we=%b, want 1 0", stray_err, mem_we);
      end
   endtask

   task automatic test_single();
      mem_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || stray_err !== 1'b0) begin
         n_fail++;
         $display("FAIL single_start: got busy=%b stray=%b, want 1 0", busy, stray_err);
      end
      drive_out(1, 2, 3, 32'h0000_1234);
      exp_q.push_back({20'h81023, ref_data(32'h0000_1234)});
      tick();
      output_valid = 1'b0;
      n_tests++;
      if (mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early: got we=%b one edge after sample, want 0", mem_we);
      end
      tick();
      n_tests++;
      if (mem_we !== 1'b1 || mem_addr !== 20'h81023 || mem_wdata !== ref_data(32'h0000_1234)) begin
         n_fail++;
         $display("FAIL single_write: got we=%b addr=%h data=%h, want 1 81023 %h",
                  mem_we, mem_addr, mem_wdata, ref_data(32'h0000_1234));
      end
      tick();
      n_tests++;
      if (mem_we !== 1'b0 || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
         n_fail++;
         $display("FAIL single_pop: got we=%b writes=%0d, want 0 1 matching", mem_we, obs_q.size());
      end
   endtask

   task automatic test_mid_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send_rand(1'b0);
         tick();
      end
      output_valid = 1'b0;
      tick(); tick();
      n_tests++;
      if (mem_we !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pending: got we=%b, want 1", mem_we);
      end
      arst_n_in = 1'b0;
      tick();
      arst_n_in = 1'b1;
      n_tests++;
      if ({mem_we, mem_addr, mem_wdata, busy, done, overflow_err, range_err, stray_err} !== 58'd0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got we=%b addr=%h data=%h busy=%b done=%b errs=%b%b%b, want all 0",
                  mem_we, mem_addr, mem_wdata, busy, done, overflow_err, range_err, stray_err);
      end
      mem_ready = 1'b1;
      send_rand(1'b0);
      tick();
      output_valid = 1'b0;
      tick(); tick();
      n_tests++;
      if (stray_err !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_idle: got stray=%b we=%b busy=%b, want 1 0 0", stray_err, mem_we, busy);
      end
      do_reset();
   endtask

   task automatic test_back_pressure();
      int c;
      mem_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         send_rand(i < 8);
         tick();
      end
      output_valid = 1'b0;
      tick();
      n_tests++;
      if (overflow_err !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_overflow: got %b, want 1", overflow_err);
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL bp_hold: got we=%b %h, want 1 %h", mem_we, {mem_addr, mem_wdata}, exp_q[0]);
         end
         tick();
      end
      mem_ready = 1'b1;
      c = 0;
      while (obs_q.size() < 8 && c < 40) begin
         tick();
         c++;
      end
      tick(); tick();
      n_tests++;
      if (obs_q.size() != 8 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_count: got %0d writes we=%b, want 8 0", obs_q.size(), mem_we);
      end
      for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL bp_order[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
         end
      end
      do_reset();
   endtask

   task automatic test_full_push_pop();
      int c;
      mem_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         send_rand(1'b1);
         tick();
      end
      output_valid = 1'b0;
      mem_ready = 1'b1;
      tick();
      n_tests++;
      if (overflow_err !== 1'b0 || mem_we !== 1'b1) begin
         n_fail++;
         $display("FAIL fullpp_accept: got ovf=%b we=%b, want 0 1", overflow_err, mem_we);
      end
      c = 0;
      while (obs_q.size() < 9 && c < 40) begin
         tick();
         c++;
      end
      tick(); tick();
      n_tests++;
      if (obs_q.size() != 9) begin
         n_fail++;
         $display("FAIL fullpp_count: got %0d writes, want 9", obs_q.size());
      end
      for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL fullpp_order[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
         end
      end
      drive_out(5, 3, 7, $urandom);
      tick();
      output_valid = 1'b0;
      tick(); tick(); tick();
      n_tests++;
      if (range_err !== 1'b1 || overflow_err !== 1'b0 || obs_q.size() != 9 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL range_drop: got rng=%b ovf=%b writes=%0d we=%b, want 1 0 9 0",
                  range_err, overflow_err, obs_q.size(), mem_we);
      end
      do_reset();
   endtask

   task automatic test_full_layer();
      int unsigned idx;
      int c, bad;
      logic [19:0] last_addr;
      idx = 0;
      c = 0;
      done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (idx < TOTAL && c < 60000) begin
         mem_ready = ($urandom_range(0, 3) != 0);
         start     = (c == 200);
         if ((exp_q.size() - obs_q.size()) < DEPTH && $urandom_range(0, 3) != 0) begin
            logic [31:0] d;
            int unsigned x, y, ch;
            d  = $urandom;
            ch = idx % OCH;
            x  = (idx / OCH) % FMW;
            y  = idx / (OCH * FMW);
            drive_out(x, y, ch, d);
            exp_q.push_back({ref_addr(x, y, ch), ref_data(d)});
            idx++;
         end else begin
            output_valid = 1'b0;
         end
         tick();
         c++;
      end
      start = 1'b0;
      output_valid = 1'b0;
      mem_ready = 1'b1;
      c = 0;
      while (done_cnt == 0 && c < 200) begin
         tick();
         c++;
      end
      tick(); tick(); tick();
      n_tests++;
      if (done_cnt != 1 || done_busy !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL layer_done: got pulses=%0d busy_at_done=%b busy=%b, want 1 0 0",
                  done_cnt, done_busy, busy);
      end
      n_tests++;
      if (obs_q.size() != TOTAL) begin
         n_fail++;
         $display("FAIL layer_count: got %0d writes, want %0d", obs_q.size(), TOTAL);
      end
      last_addr = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1][51:32] : 20'h0;
      n_tests++;
      if (last_addr !== 20'(32'h8_0000 + TOTAL - 1)) begin
         n_fail++;
         $display("FAIL layer_last: got %h, want %h", last_addr, 20'(32'h8_0000 + TOTAL - 1));
      end
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL layer_data: got %0d mismatching writes, want 0", bad);
      end
      n_tests++;
      if ({overflow_err, range_err, stray_err} !== 3'b000) begin
         n_fail++;
         $display("FAIL layer_errs: got %b%b%b, want 000", overflow_err, range_err, stray_err);
      end
      do_reset();
   endtask

`ifdef WB_QUANTIZE_EN
   task automatic test_quantize();
      int c;
      mem_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      drive_out(0, 0, 0, 32'h0100_0000);
      tick();
      drive_out(0, 0, 1, 32'hFFFF_FF00);
      tick();
      output_valid = 1'b0;
      c = 0;
      while (obs_q.size() < 2 && c < 20) begin
         tick();
         c++;
      end
      n_tests++;
      if (obs_q.size() < 2 || obs_q[0][31:0] !== 32'h0000_7FFF || obs_q[1][31:0] !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL quantize: got %0d writes first=%h second=%h, want 00007fff ffffffff",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0][31:0] : 32'h0,
                  (obs_q.size() > 1) ? obs_q[1][31:0] : 32'h0);
      end
      do_reset();
   endtask
`endif

   initial begin
      test_reset();
      test_stray();
      test_single();
      test_mid_reset();
      test_back_pressure();
      test_full_push_pop();
      test_full_layer();
`ifdef WB_QUANTIZE_EN
      test_quantize();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/output_writeback.md
Name: output_writeback

Overview:
- Downstream neighbour of top_system.
- Consumes the accelerator's output stream (out, output_valid, output_x, output_y, output_ch) and computes the linear external-memory address of each output.
- Buffers entries in a small FIFO and writes them to external memory over a valid/ready write port.
- Tracks layer completion and reports sticky error flags, because top_system offers no output back-pressure.

Parameters:
- ACCUMULATION_WIDTH, 32, width of out and mem_wdata.
- DATA_WIDTH, 16, quantized output width (used only with the optional feature).
- EXT_MEM_HEIGHT, 1<<20, external memory depth; AW = $clog2(EXT_MEM_HEIGHT).
- FEATURE_MAP_WIDTH, 64, output x extent.
- FEATURE_MAP_HEIGHT, 64, output y extent.
- OUTPUT_NB_CHANNELS, 32, output channel extent.
- OUT_BASE, 20'h80000, base address of the output region.
- FIFO_DEPTH, 8, write-buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- arst_n_in  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; arms the block for one layer.
- out  in  ACCUMULATION_WIDTH  accelerator output value.
- output_valid  in  1  out and coordinates are valid this cycle.
- output_x  in  $clog2(FEATURE_MAP_WIDTH)  x coordinate.
- output_y  in  $clog2(FEATURE_MAP_HEIGHT)  y coordinate.
- output_ch  in  $clog2(OUTPUT_NB_CHANNELS)  channel.
- mem_we  out  1  write request (valid).
- mem_ready  in  1  memory accepts the write.
- mem_addr  out  AW  write address.
- mem_wdata  out  ACCUMULATION_WIDTH  write data.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the layer is fully written.
- overflow_err  out  1  sticky: an output was dropped because the FIFO was full.
- range_err  out  1  sticky: a coordinate was out of range.
- stray_err  out  1  sticky: output_valid was seen while not in RUN.

Behaviour:
- Reset (arst_n_in low at a clk edge):
  - state goes to IDLE; FIFO, pipeline register and counters are cleared.
  - All outputs are 0.
  - Reset mid-layer abandons in-flight data silently.
- States:
  - IDLE: start leads to RUN. Counters and error flags clear on entry to RUN.
  - RUN: accepts outputs. When the accepted count reaches TOTAL = W*H*OC, go to DRAIN.
  - DRAIN: when the FIFO and pipeline register are empty and no write is pending, go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- Address stage (S1):
  - At the edge where output_valid is sampled in RUN, register addr = OUT_BASE + (y*FEATURE_MAP_WIDTH + x)*OUTPUT_NB_CHANNELS + ch.
  - Compute in AW+1 bits and truncate to AW, so the address wraps modulo EXT_MEM_HEIGHT.
  - The data is registered alongside the address.
- Push: at the next edge the S1 entry is pushed into the FIFO.
  - The FIFO head drives mem_addr and mem_wdata from registers.
  - mem_we = FIFO not empty.
  - Minimum latency: mem_we rises after the second edge following the sampling of output_valid.
- Write handshake:
  - A write transfers on an edge where mem_we && mem_ready; the entry is popped.
  - mem_addr and mem_wdata hold stable while mem_we is high and mem_ready is low.
- Simultaneous push and pop on a full FIFO: the push is accepted (the pop frees the slot).
- Push to a full FIFO without a pop: the entry is dropped and overflow_err is set. It still counts toward TOTAL, so completion is not blocked.
- Range check: x >= FEATURE_MAP_WIDTH, y >= FEATURE_MAP_HEIGHT or ch >= OUTPUT_NB_CHANNELS sets range_err. The entry is dropped but still counts. This is only possible with non-power-of-two extents.
- output_valid in IDLE, DRAIN or DONE is dropped and sets stray_err.
- Sticky errors clear only on reset or on entry to RUN.
- busy = (state == RUN || state == DRAIN).

Optional Feature:
- Macro WB_QUANTIZE_EN, with parameter QUANT_SHIFT (default 8).
- Defined:
  - S1 arithmetic-right-shifts out by QUANT_SHIFT.
  - The result saturates to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - The saturated value is sign-extended to ACCUMULATION_WIDTH for mem_wdata.
  - Latency is unchanged.
- Undefined: out passes through unmodified and QUANT_SHIFT is unused.

Decomposition:
- Package cpaed_wb_pkg holds:
  - wb_state_e (IDLE, RUN, DRAIN, DONE).
  - A typedef for the FIFO entry struct {addr, data}.
  - A function wb_addr(x, y, ch) implementing the address formula.
  - The saturate function used by WB_QUANTIZE_EN.
- Sub-module wb_fifo: synchronous FIFO parameterized by width and depth.
  - Ports push, pop, full, empty, din, dout.
  - Same clk/arst_n_in convention.

Test Plan:
- Single output:
  - Stimulus: start; then out=32'h0000_1234 with x=1, y=2, ch=3 and mem_ready=1.
  - Required: mem_we=1 two edges later, with mem_addr=20'h81023 and mem_wdata=32'h0000_1234.
- Back-pressure:
  - Stimulus: mem_ready=0 while 8 consecutive outputs arrive; then a 9th arrives, then mem_ready=1.
  - Required: the 9th output is dropped and overflow_err=1. The first 8 are written in order with the head held stable while stalled.
- Full layer:
  - Stimulus: stream all 131072 outputs with mem_ready=1.
  - Required: done pulses exactly once and busy falls with it. The write count is 131072 and address 20'h80000+131071 is the last written.
- Full FIFO, simultaneous push and pop:
  - Stimulus: FIFO full, mem_ready=1, output_valid=1 in the same cycle.
  - Required: the entry is accepted and overflow_err stays 0.
- Stray output and mid-layer reset:
  - Stimulus: output_valid while in IDLE, then arst_n_in=0 for one edge mid-RUN.
  - Required: stray_err=1 after the IDLE output. After the reset edge, all outputs are 0 and the state is IDLE.
- Quantization (WB_QUANTIZE_EN defined):
  - Stimulus: out=32'h0100_0000 and out=32'hFFFF_FF00.
  - Required: mem_wdata=32'h0000_7FFF (saturated) and mem_wdata=32'hFFFF_FFFF (-1).
